int_regfile_scoreboard: RTL and testbench

- Integer architectural register file plus busy-bit scoreboard. It is the consumer of the writeback stage's register-writeback bundle and flush signal.
- Issue marks destination registers busy. Writeback commits data and clears busy. Flush clears all outstanding busy bits.
- Provides bypassed source operands and an issue stall to the issue stage.

---
 rtl/int_regfile_scoreboard_if.sv | 37 +++
 rtl/int_regfile_scoreboard.sv | 123 ++++++++++++
 tb/tb_int_regfile_scoreboard.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_regfile_scoreboard_if.sv
// Issue/writeback bundle between the writeback stage, the issue stage and
// the integer register file / busy-bit scoreboard.
interface int_regfile_scoreboard_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
);
  logic             i_wb_valid;
  logic [IDX_W-1:0] i_wb_idx;
  logic [XLEN-1:0]  i_wb_data;
  logic             i_flush;
  logic             i_issue_valid;
  logic [IDX_W-1:0] i_rs1_idx;
  logic             i_rs1_used;
  logic [IDX_W-1:0] i_rs2_idx;
  logic             i_rs2_used;
  logic [IDX_W-1:0] i_rd_idx;
  logic             i_rd_wr;
  logic [XLEN-1:0]  o_rs1_data;
  logic [XLEN-1:0]  o_rs2_data;
  logic             o_stall;
  logic             o_ready;
  logic [IDX_W:0]   o_busy_count;

  modport slave (
    input  i_wb_valid, i_wb_idx, i_wb_data, i_flush,
    input  i_issue_valid, i_rs1_idx, i_rs1_used, i_rs2_idx, i_rs2_used,
    input  i_rd_idx, i_rd_wr,
    output o_rs1_data, o_rs2_data, o_stall, o_ready, o_busy_count
  );

  modport master (
    output i_wb_valid, i_wb_idx, i_wb_data, i_flush,
    output i_issue_valid, i_rs1_idx, i_rs1_used, i_rs2_idx, i_rs2_used,
    output i_rd_idx, i_rd_wr,
    input  o_rs1_data, o_rs2_data, o_stall, o_ready, o_busy_count
  );
endinterface

// File: rtl/int_regfile_scoreboard.sv
// Integer architectural register file with busy-bit scoreboard.
// After reset an INIT sweep zeroes x1..x(N-1), then RUN serves bypassed
// operands, a RAW/WAW issue stall and a registered busy count.
module int_regfile_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int IDX_W    = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  int_regfile_scoreboard_if.slave  bus
);

  typedef enum logic {INIT, RUN} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    init_ptr;
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic [XLEN-1:0]     regs [NUM_REGS];
  logic                ready_q;
  logic [IDX_W:0]      busy_cnt_q, busy_cnt_nxt;
  logic                stall, accept;
  logic                wb_commit;
  logic                eff_busy_rs1, eff_busy_rs2, eff_busy_rd;
  logic [XLEN-1:0]     rs1_data, rs2_data;

  // x0 is never a real destination: writeback to it is dropped entirely
  assign wb_commit = bus.i_wb_valid & (bus.i_wb_idx != '0);

  // A writeback in flight releases its register for hazard purposes now
  assign eff_busy_rs1 = busy[bus.i_rs1_idx] &
                        ~(bus.i_wb_valid & (bus.i_wb_idx == bus.i_rs1_idx));
  assign eff_busy_rs2 = busy[bus.i_rs2_idx] &
                        ~(bus.i_wb_valid & (bus.i_wb_idx == bus.i_rs2_idx));
  assign eff_busy_rd  = busy[bus.i_rd_idx] &
                        ~(bus.i_wb_valid & (bus.i_wb_idx == bus.i_rd_idx));

  // State register, init sweep pointer, busy vector and registered status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= INIT;
      init_ptr   <= IDX_W'(1);
      busy       <= '0;
      ready_q    <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      state      <= state_nxt;
      if (state == INIT) init_ptr <= init_ptr + IDX_W'(1);
      busy       <= busy_nxt;
      ready_q    <= (state_nxt == RUN);
      busy_cnt_q <= busy_cnt_nxt;
    end
  end

  // Next state plus stall/accept; INIT holds issue off unconditionally
  always_comb begin
    state_nxt = state;
    stall     = 1'b1;
    accept    = 1'b0;
    case (state)
      INIT: begin
        if (init_ptr == IDX_W'(NUM_REGS - 1)) state_nxt = RUN;
      end
      RUN: begin
        stall  = bus.i_issue_valid &
                 ((bus.i_rs1_used & eff_busy_rs1) |
                  (bus.i_rs2_used & eff_busy_rs2) |
                  (bus.i_rd_wr & (bus.i_rd_idx != '0) & eff_busy_rd));
        accept = bus.i_issue_valid & ~stall & ~bus.i_flush;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Busy update: writeback clears, flush clears all, issue set wins over clear
  always_comb begin
    busy_nxt = busy;
    if (state == RUN) begin
      if (wb_commit) busy_nxt[bus.i_wb_idx] = 1'b0;
      if (bus.i_flush)
        busy_nxt = '0;
      else if (accept & bus.i_rd_wr & (bus.i_rd_idx != '0))
        busy_nxt[bus.i_rd_idx] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Popcount of the next busy vector so the count lines up with busy
  always_comb begin
    busy_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_cnt_nxt = busy_cnt_nxt + {{IDX_W{1'b0}}, busy_nxt[i]};
  end

  // Register array: no reset, zeroed by the INIT sweep instead
  always_ff @(posedge i_clk) begin
    if (state == INIT)
      regs[init_ptr] <= '0;
    else if (wb_commit)
      regs[bus.i_wb_idx] <= bus.i_wb_data;
  end

  // Operand read with same-cycle writeback bypass; x0 and INIT read zero
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (state == RUN) begin
      if (bus.i_rs1_idx != '0)
        rs1_data = (bus.i_wb_valid & (bus.i_wb_idx == bus.i_rs1_idx)) ?
                   bus.i_wb_data : regs[bus.i_rs1_idx];
      if (bus.i_rs2_idx != '0)
        rs2_data = (bus.i_wb_valid & (bus.i_wb_idx == bus.i_rs2_idx)) ?
                   bus.i_wb_data : regs[bus.i_rs2_idx];
    end
  end

  assign bus.o_rs1_data   = rs1_data;
  assign bus.o_rs2_data   = rs2_data;
  assign bus.o_stall      = stall;
  assign bus.o_ready      = ready_q;
  assign bus.o_busy_count = busy_cnt_q;

endmodule

// File: tb/tb_int_regfile_scoreboard.sv
// Scoreboard bench for int_regfile_scoreboard: directed scenarios followed
// by random traffic, checked against an architectural reference model.
module tb_int_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int IDX_W = 5;
  localparam int NREG  = 32;

  logic i_clk = 1'b0;
  logic i_rst_n;

  always #5 i_clk = ~i_clk;

  int_regfile_scoreboard_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus();

  int_regfile_scoreboard #(.NUM_REGS(NREG), .XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        stall;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        rdy;
    int          bc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: architectural contents, busy set, remaining init cycles
  logic [31:0] m_mem [NREG];
  bit          m_busy [NREG];
  int          init_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic logic [31:0] m_rd(input bit [4:0] idx, input bit wbv,
                                       input bit [4:0] wbi, input bit [31:0] wbd);
    if (idx == 0) return 32'h0;
    if (wbv && wbi == idx) return wbd;
    return m_mem[idx];
  endfunction

  function automatic bit m_eff(input bit [4:0] idx, input bit wbv, input bit [4:0] wbi);
    return m_busy[idx] && !(wbv && wbi == idx);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = 32'h0;
      m_busy[i] = 1'b0;
    end
    init_left = 31;
  endtask

  task automatic idle_inputs();
    bus.i_wb_valid = 0; bus.i_wb_idx = 0; bus.i_wb_data = 0; bus.i_flush = 0;
    bus.i_issue_valid = 0; bus.i_rs1_idx = 0; bus.i_rs1_used = 0;
    bus.i_rs2_idx = 0; bus.i_rs2_used = 0; bus.i_rd_idx = 0; bus.i_rd_wr = 0;
  endtask

  // one cycle: drive, push expectation, advance model across the edge
  task automatic step(input bit wbv, input bit [4:0] wbi, input bit [31:0] wbd,
                      input bit fl, input bit iv,
                      input bit [4:0] r1, input bit u1,
                      input bit [4:0] r2, input bit u2,
                      input bit [4:0] rd, input bit rdw);
    exp_t e;
    bit   st;
    bus.i_wb_valid = wbv; bus.i_wb_idx = wbi; bus.i_wb_data = wbd; bus.i_flush = fl;
    bus.i_issue_valid = iv; bus.i_rs1_idx = r1; bus.i_rs1_used = u1;
    bus.i_rs2_idx = r2; bus.i_rs2_used = u2; bus.i_rd_idx = rd; bus.i_rd_wr = rdw;
    if (init_left > 0) begin
      st = 1'b1; e.d1 = 32'h0; e.d2 = 32'h0;
    end else begin
      st = iv && ((u1 && m_eff(r1, wbv, wbi)) || (u2 && m_eff(r2, wbv, wbi)) ||
                  (rdw && rd != 0 && m_eff(rd, wbv, wbi)));
      e.d1 = m_rd(r1, wbv, wbi, wbd);
      e.d2 = m_rd(r2, wbv, wbi, wbd);
    end
    e.stall = st;
    e.rdy   = (init_left == 0);
    e.bc    = m_count();
    q.push_back(e);
    @(posedge i_clk);
    if (init_left > 0) init_left--;
    else begin
      if (wbv && wbi != 0) begin m_mem[wbi] = wbd; m_busy[wbi] = 1'b0; end
      if (fl) for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
      else if (iv && !st && rdw && rd != 0) m_busy[rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_step();
    bit [4:0] wi, a, b, d;
    wi = 5'($urandom_range(0, 9));
    a  = 5'($urandom_range(0, 9));
    b  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
    d  = 5'($urandom_range(0, 9));
    step($urandom_range(0, 1) == 1, wi, $urandom, $urandom_range(0, 19) == 0,
         $urandom_range(0, 9) < 7, a, $urandom_range(0, 1) == 1,
         b, $urandom_range(0, 1) == 1, d, $urandom_range(0, 3) != 0);
  endtask

  // called at posedge+1 with the expectation queue already drained
  task automatic mid_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'h0, bus.o_ready}, 32'h0);
    chk("rst_busy_count", {26'h0, bus.o_busy_count}, 32'h0);
    chk("rst_stall", {31'h0, bus.o_stall}, 32'h1);
    idle_inputs();
    m_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  // monitor: compare every pending expectation away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", {31'h0, bus.o_stall}, {31'h0, e.stall});
        chk("rs1_data", bus.o_rs1_data, e.d1);
        chk("rs2_data", bus.o_rs2_data, e.d2);
        chk("ready", {31'h0, bus.o_ready}, {31'h0, e.rdy});
        chk("busy_count", {26'h0, bus.o_busy_count}, 32'(e.bc));
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    idle_inputs();
    m_reset();
    #1;
    chk("por_ready", {31'h0, bus.o_ready}, 32'h0);
    chk("por_busy_count", {26'h0, bus.o_busy_count}, 32'h0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;

    // INIT with junk on the ignored inputs
    for (int i = 0; i < 31; i++)
      step(1, 5'(i + 1), $urandom, $urandom_range(0, 1) == 1, 1, 5'(i + 1), 1, 5'd3, 1, 5'd2, 1);
    // every register reads zero after the sweep
    for (int i = 1; i < NREG; i++) step(0, 0, 0, 0, 0, 5'(i), 0, 5'(NREG - i), 0, 0, 0);

    // bypass, array visibility, x0 discard
    step(1, 5, 32'hDEADBEEF, 0, 0, 5, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    step(1, 0, 32'h1234, 0, 0, 0, 1, 0, 1, 0, 0);
    idle_step();

    // RAW on x7 released by writeback in the same cycle
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 7, 1);
    step(0, 0, 0, 0, 1, 0, 0, 7, 1, 2, 1);
    step(0, 0, 0, 0, 1, 0, 0, 7, 1, 2, 1);
    step(1, 7, 32'h55, 0, 1, 0, 0, 7, 1, 0, 0);
    idle_step();

    // WAW on x9: stall, then set wins over the same-cycle clear
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 9, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 9, 1);
    step(1, 9, 32'h99, 0, 1, 0, 0, 0, 0, 9, 1);
    idle_step();
    step(1, 9, 32'h999, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_step();

    // flush with concurrent writeback and dropped issue
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 4, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 6, 1);
    step(1, 3, 32'hA, 1, 1, 0, 0, 0, 0, 8, 1);
    step(0, 0, 0, 0, 1, 3, 1, 8, 1, 8, 1);
    idle_step();

    // reset mid-operation with busy registers outstanding
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 10, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 11, 1);
    mid_reset();
    for (int i = 0; i < 31; i++) idle_step();
    step(0, 0, 0, 0, 0, 5, 1, 3, 1, 0, 0);
    step(0, 0, 0, 0, 0, 9, 1, 7, 1, 0, 0);
    step(0, 0, 0, 0, 1, 10, 1, 11, 1, 10, 1);

    // random traffic
    for (int i = 0; i < 2000; i++) rnd_step();
    mid_reset();
    for (int i = 0; i < 600; i++) rnd_step();

    idle_inputs();
    @(negedge i_clk); #1;
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
